// File: rtl/pmm_feeder_if.sv
// PMM-side handshake bundle: data/control words plus the four-phase
// DATA_VALID / READY_STATUS pair and the ACCEPTED_STATUS match result.
interface pmm_feeder_if;
    logic [63:0] INP_DATA;
    logic [15:0] INP_CONTROL;
    logic        DATA_VALID;
    logic        READY_STATUS;
    logic        ACCEPTED_STATUS;

    modport master (
        output INP_DATA,
        output INP_CONTROL,
        output DATA_VALID,
        input  READY_STATUS,
        input  ACCEPTED_STATUS
    );

    modport slave (
        input  INP_DATA,
        input  INP_CONTROL,
        input  DATA_VALID,
        output READY_STATUS,
        output ACCEPTED_STATUS
    );
endinterface

// File: rtl/pmm_feeder.sv
// Host-side PMM initiator: word FIFO feeding a four-phase DATA_VALID/READY_STATUS
// handshake, with match/transfer statistics. Optional SEND timeout: PMM_FEEDER_TIMEOUT_EN.
module pmm_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [63:0]            wr_data,
    input  logic [15:0]            wr_ctrl,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    pmm_feeder_if.master           pmm,
    output logic                   busy,
    output logic                   last_match,
    output logic [15:0]            match_count,
    output logic [15:0]            sent_count,
    output logic                   overflow,
    output logic                   timeout_err,
    input  logic                   clr_status
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pmm_feeder: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("pmm_feeder: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RELEASE
    } state_t;

    typedef struct packed {
        logic [15:0] ctrl;
        logic [63:0] data;
    } entry_t;

    state_t        r_state;
    state_t        w_state_nxt;
    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [63:0]   r_inp_data;
    logic [15:0]   r_inp_ctrl;
    logic          r_last_match;
    logic [15:0]   r_match_count;
    logic [15:0]   r_sent_count;
    logic          r_overflow;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_accept;
    logic          w_abort;
    logic          w_to_hit;

    assign full   = (r_level == LW'(DEPTH));
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign w_push = wr_en && !full;
    assign w_pop  = w_accept || w_abort;

    // NOTE: storage array carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{ctrl: wr_ctrl, data: wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!empty && !pmm.READY_STATUS) begin
                    w_state_nxt = ST_SEND;
                    w_load      = 1'b1;
                end
            end
            ST_SEND: begin
                if (pmm.READY_STATUS) begin
                    w_state_nxt = ST_RELEASE;
                    w_accept    = 1'b1;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_RELEASE;
                    w_abort     = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!pmm.READY_STATUS) begin
                    if (!empty) begin
                        w_state_nxt = ST_SEND;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inp_data <= '0;
            r_inp_ctrl <= '0;
        end else if (w_load) begin
            r_inp_data <= r_mem[r_rd_ptr].data;
            r_inp_ctrl <= r_mem[r_rd_ptr].ctrl;
        end
    end

    // clr_status outranks same-cycle increments and sticky sets.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_match  <= 1'b0;
            r_match_count <= '0;
            r_sent_count  <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_accept) r_last_match <= pmm.ACCEPTED_STATUS;
            if (clr_status) begin
                r_match_count <= '0;
                r_sent_count  <= '0;
                r_overflow    <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_sent_count <= r_sent_count + 16'd1;
                    if (pmm.ACCEPTED_STATUS && r_match_count != 16'hFFFF) begin
                        r_match_count <= r_match_count + 16'd1;
                    end
                end
                if (wr_en && full) r_overflow <= 1'b1;
            end
        end
    end

`ifdef PMM_FEEDER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TW-1:0] r_to_cnt;
    logic          r_timeout_err;

    // Counts SEND cycles since the load; the abort lands on the TIMEOUT-th low cycle's edge.
    always_ff @(posedge clk) begin
        if (reset || w_load) r_to_cnt <= '0;
        else if (r_state == ST_SEND) r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_to_hit = (r_state == ST_SEND) && (r_to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clr_status) r_timeout_err <= 1'b0;
        else if (w_abort)        r_timeout_err <= 1'b1;
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_to_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign pmm.INP_DATA    = r_inp_data;
    assign pmm.INP_CONTROL = r_inp_ctrl;
    assign pmm.DATA_VALID  = (r_state == ST_SEND);
    assign busy            = (r_state != ST_IDLE);
    assign last_match      = r_last_match;
    assign match_count     = r_match_count;
    assign sent_count      = r_sent_count;
    assign overflow        = r_overflow;

endmodule

// File: doc/pmm_feeder.md
# pmm_feeder

Host-side initiator for one pattern-matching module (PMM) channel. It buffers 64-bit data words with their 16-bit control words in a small FIFO and presents them to the PMM using the four-phase DATA_VALID / READY_STATUS handshake. It samples ACCEPTED_STATUS on each accepted word and keeps match and transfer statistics. One instance sits in front of each PMM slot of the peripheral and drives that slot's data, control and data-ready lines.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- TIMEOUT, 255: SEND-state cycle limit; used only with PMM_FEEDER_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  push request.
- wr_data  in  64  data word to push.
- wr_ctrl  in  16  control word to push, paired with wr_data.
- full  out  1  high when level == DEPTH.
- empty  out  1  high when level == 0.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- INP_DATA  out  64  data presented to the PMM.
- INP_CONTROL  out  16  control presented to the PMM.
- DATA_VALID  out  1  handshake request to the PMM.
- READY_STATUS  in  1  handshake acknowledge from the PMM.
- ACCEPTED_STATUS  in  1  PMM pattern-match result.
- busy  out  1  high when the state is not IDLE.
- last_match  out  1  ACCEPTED_STATUS captured on the most recent accept.
- match_count  out  16  number of accepts with ACCEPTED_STATUS == 1; saturates at 0xFFFF.
- sent_count  out  16  number of accepted words; wraps modulo 2^16.
- overflow  out  1  sticky; set when a push is dropped.
- timeout_err  out  1  sticky; set when a transfer is aborted by timeout.
- clr_status  in  1  clears overflow, timeout_err, match_count and sent_count.

## Operation
- FIFO: registered push and pop; head entry {wr_ctrl, wr_data}.
- A push with full == 1 is dropped and sets overflow. This holds even if a pop happens in the same cycle.
- A push and a pop in the same cycle with full == 0 leave level unchanged.
- State machine:
  - IDLE -> SEND when empty == 0 and READY_STATUS == 0. On that edge, load INP_DATA/INP_CONTROL from the FIFO head and set DATA_VALID = 1.
  - SEND -> RELEASE when READY_STATUS == 1. On that edge:
    - clear DATA_VALID;
    - pop the head entry;
    - set last_match to ACCEPTED_STATUS;
    - increment sent_count;
    - increment match_count if ACCEPTED_STATUS == 1.
  - RELEASE -> SEND when READY_STATUS == 0 and empty == 0, loading the next head entry.
  - RELEASE -> IDLE when READY_STATUS == 0 and empty == 1.
- INP_DATA and INP_CONTROL hold their value from load until the next load. They never change while DATA_VALID == 1.
- clr_status has priority over same-cycle increments and sets. The cleared value wins.
- Reset values:
  - state IDLE; level 0, so empty = 1 and full = 0;
  - DATA_VALID, busy, last_match, overflow and timeout_err all 0;
  - INP_DATA, INP_CONTROL, match_count and sent_count all 0.
- Reset mid-transfer: DATA_VALID is 0 after the reset edge and the FIFO is flushed. The next SEND waits for READY_STATUS == 0, so a stale acknowledge is never counted.

## Timing
- Push latency: a push at edge N into an empty FIFO, in IDLE with READY_STATUS low, gives DATA_VALID = 1 after edge N+1.
- DATA_VALID falls on the edge after READY_STATUS is first sampled high.
- Back-to-back words: a PMM that acknowledges in the same cycle gives one word per 2 cycles, alternating SEND and RELEASE.
- full, empty and level update on the push/pop edge. There is no combinational path from wr_en to them.
- There is no combinational path from READY_STATUS to any output.

## Configuration
- PMM_FEEDER_TIMEOUT_EN defined:
  - An 8+ bit counter runs in SEND.
  - If READY_STATUS stays low for TIMEOUT consecutive SEND cycles, the next edge clears DATA_VALID, pops the entry, sets timeout_err and enters RELEASE.
  - A timed-out word does not change sent_count, match_count or last_match.
- PMM_FEEDER_TIMEOUT_EN undefined:
  - SEND waits indefinitely.
  - timeout_err is tied to 0 and no counter logic is present.

## Test plan
- Single word: push 0x0123456789ABCDEF / ctrl 0x0005. The PMM model acknowledges 3 cycles after DATA_VALID with ACCEPTED_STATUS = 1. Required: INP_DATA and INP_CONTROL match the push, DATA_VALID falls one edge after the acknowledge, last_match = 1, match_count = 1, sent_count = 1, empty = 1.
- Stream: push 4 words with DEPTH = 4 to reach full. A 5th push sets overflow and level stays 4. All 4 words are delivered in order; sent_count = 4.
- Four-phase rule: hold READY_STATUS high for 5 cycles after the acknowledge with 2 words queued. The second DATA_VALID rises only after READY_STATUS falls, and sent_count increments exactly once per word.
- Reset in SEND: assert reset while DATA_VALID = 1 and READY_STATUS = 1. Required: all outputs at reset values next cycle. A new push does not raise DATA_VALID until READY_STATUS is low.
- Timeout (macro on, TIMEOUT = 10): the PMM never acknowledges. After 10 SEND cycles DATA_VALID drops, timeout_err = 1, sent_count = 0, and the FIFO advances.
- clr_status together with an acknowledge: match_count = 0 and sent_count = 0 after that edge.
